// File: rtl/obi_arb_pkg.sv
// obi_arb_pkg: shared types and constants for the OBI data-port arbiter.
// Rev 1.0
`default_nettype none

package obi_arb_pkg;

  localparam int NUM_REQUESTERS = 2;
  localparam int OBI_ADDR_MAX   = 64;

  typedef logic [0:0] req_id_t;

  // Address field sized for the widest supported port; users truncate to ADDR_WIDTH.
  typedef struct packed {
    logic [OBI_ADDR_MAX-1:0] addr;
    logic                    we;
    logic [3:0]              be;
    logic [31:0]             wdata;
  } obi_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } obi_rsp_t;

endpackage

`default_nettype wire

// File: rtl/obi_arb_id_fifo.sv
// obi_arb_id_fifo: in-order FIFO of requester IDs for outstanding OBI transactions.
// Rev 1.0
`default_nettype none

module obi_arb_id_fifo
  import obi_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push,
  input  req_id_t                      push_id,
  input  logic                         pop,
  output req_id_t                      head_id,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  req_id_t           slots [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  cnt;

  always_ff @(posedge clk_i) begin
    if (push) begin
      slots[wr_ptr] <= push_id;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        cnt <= cnt + CNT_W'(1);
      end else if (pop && !push) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  assign head_id = slots[rd_ptr];
  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;

endmodule

`default_nettype wire

// File: rtl/obi_data_arbiter.sv
// obi_data_arbiter: two-requester OBI arbiter with in-order response routing.
// Option OBI_ARB_ROUND_ROBIN_EN selects round-robin instead of fixed priority. Rev 1.0
`default_nettype none

module obi_data_arbiter
  import obi_arb_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   m0_req_i,
  output logic                                   m0_gnt_o,
  input  logic [ADDR_WIDTH-1:0]                  m0_addr_i,
  input  logic                                   m0_we_i,
  input  logic [3:0]                             m0_be_i,
  input  logic [31:0]                            m0_wdata_i,
  output logic                                   m0_rvalid_o,
  output logic [31:0]                            m0_rdata_o,
  output logic                                   m0_err_o,
  input  logic                                   m1_req_i,
  output logic                                   m1_gnt_o,
  input  logic [ADDR_WIDTH-1:0]                  m1_addr_i,
  input  logic                                   m1_we_i,
  input  logic [3:0]                             m1_be_i,
  input  logic [31:0]                            m1_wdata_i,
  output logic                                   m1_rvalid_o,
  output logic [31:0]                            m1_rdata_o,
  output logic                                   m1_err_o,
  output logic                                   mem_req_o,
  input  logic                                   mem_gnt_i,
  output logic [ADDR_WIDTH-1:0]                  mem_addr_o,
  output logic                                   mem_we_o,
  output logic [3:0]                             mem_be_o,
  output logic [31:0]                            mem_wdata_o,
  input  logic                                   mem_rvalid_i,
  input  logic [31:0]                            mem_rdata_i,
  input  logic                                   mem_err_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o,
  output logic                                   protocol_err_o
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [0:0]                 state_q, state_d;
  req_id_t                    owner_q, owner_d;
  req_id_t                    winner, sel_id, head_id;
  logic [NUM_REQUESTERS-1:0]  req_vec;
  obi_req_t                   req_in [NUM_REQUESTERS];
  obi_req_t                   sel_req;
  obi_rsp_t                   mem_rsp;
  logic                       fwd, push, pop;
  logic                       fifo_full, fifo_empty;
  logic [CNT_W-1:0]           fifo_count;
  logic                       perr_q;
  logic                       unused_addr;

  assign req_vec   = {m1_req_i, m0_req_i};
  assign req_in[0] = '{addr: OBI_ADDR_MAX'(m0_addr_i), we: m0_we_i, be: m0_be_i, wdata: m0_wdata_i};
  assign req_in[1] = '{addr: OBI_ADDR_MAX'(m1_addr_i), we: m1_we_i, be: m1_be_i, wdata: m1_wdata_i};
  assign mem_rsp   = '{rdata: mem_rdata_i, err: mem_err_i};

`ifdef OBI_ARB_ROUND_ROBIN_EN
  req_id_t rr_q;

  // rr_q names the favoured requester: the one not granted most recently.
  always_comb begin
    winner = req_vec[1] & ~req_vec[0];
    if (&req_vec) begin
      winner = rr_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q <= '0;
    end else if (push) begin
      rr_q <= ~sel_id;
    end
  end
`else
  assign winner = req_vec[1] & ~req_vec[0];
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    sel_id  = winner;
    fwd     = !fifo_full && (|req_vec);
    if (state_q == ST_HOLD) begin
      sel_id = owner_q;
      fwd    = !fifo_full;
    end
    if (rst_i) begin
      fwd = 1'b0;
    end
    push = fwd && mem_gnt_i;
    if (fwd && !mem_gnt_i && (state_q == ST_IDLE)) begin
      state_d = ST_HOLD;
      owner_d = winner;
    end
    if (push) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      if (mem_rvalid_i && fifo_empty) begin
        perr_q <= 1'b1;
      end
    end
  end

  obi_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push    (push),
    .push_id (sel_id),
    .pop     (pop),
    .head_id (head_id),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign sel_req     = req_in[sel_id];
  assign unused_addr = ^sel_req.addr;

  assign mem_req_o   = fwd;
  assign mem_addr_o  = fwd ? sel_req.addr[ADDR_WIDTH-1:0] : '0;
  assign mem_we_o    = fwd & sel_req.we;
  assign mem_be_o    = fwd ? sel_req.be : 4'h0;
  assign mem_wdata_o = fwd ? sel_req.wdata : 32'h0;
  assign m0_gnt_o    = push && (sel_id == 1'b0);
  assign m1_gnt_o    = push && (sel_id == 1'b1);

  // Responses with nothing outstanding are dropped, never routed.
  assign pop         = mem_rvalid_i && !fifo_empty && !rst_i;
  assign m0_rvalid_o = pop && (head_id == 1'b0);
  assign m1_rvalid_o = pop && (head_id == 1'b1);
  assign m0_rdata_o  = m0_rvalid_o ? mem_rsp.rdata : 32'h0;
  assign m1_rdata_o  = m1_rvalid_o ? mem_rsp.rdata : 32'h0;
  assign m0_err_o    = m0_rvalid_o & mem_rsp.err;
  assign m1_err_o    = m1_rvalid_o & mem_rsp.err;

  assign outstanding_o  = rst_i ? '0 : fifo_count;
  assign protocol_err_o = perr_q & ~rst_i;

endmodule

`default_nettype wire

// File: tb/tb_obi_data_arbiter.sv
// tb_obi_data_arbiter: directed self-checking bench for obi_data_arbiter (MAX_OUTSTANDING=2).
// Rev 1.0
`default_nettype none

module tb_obi_data_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_gnt, m0_we, m0_rvalid, m0_err;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic [3:0]  m0_be;
  logic        m1_req, m1_gnt, m1_we, m1_rvalid, m1_err;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m1_be;
  logic        mem_req, mem_gnt, mem_we, mem_rvalid, mem_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic [1:0]  outstanding;
  logic        perr;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  obi_data_arbiter #(
    .ADDR_WIDTH      (32),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .m0_req_i       (m0_req),
    .m0_gnt_o       (m0_gnt),
    .m0_addr_i      (m0_addr),
    .m0_we_i        (m0_we),
    .m0_be_i        (m0_be),
    .m0_wdata_i     (m0_wdata),
    .m0_rvalid_o    (m0_rvalid),
    .m0_rdata_o     (m0_rdata),
    .m0_err_o       (m0_err),
    .m1_req_i       (m1_req),
    .m1_gnt_o       (m1_gnt),
    .m1_addr_i      (m1_addr),
    .m1_we_i        (m1_we),
    .m1_be_i        (m1_be),
    .m1_wdata_i     (m1_wdata),
    .m1_rvalid_o    (m1_rvalid),
    .m1_rdata_o     (m1_rdata),
    .m1_err_o       (m1_err),
    .mem_req_o      (mem_req),
    .mem_gnt_i      (mem_gnt),
    .mem_addr_o     (mem_addr),
    .mem_we_o       (mem_we),
    .mem_be_o       (mem_be),
    .mem_wdata_o    (mem_wdata),
    .mem_rvalid_i   (mem_rvalid),
    .mem_rdata_i    (mem_rdata),
    .mem_err_i      (mem_err),
    .outstanding_o  (outstanding),
    .protocol_err_o (perr)
  );

  task automatic idle_inputs();
    m0_req = 0; m0_addr = 0; m0_we = 0; m0_be = 4'hF; m0_wdata = 0;
    m1_req = 0; m1_addr = 0; m1_we = 0; m1_be = 4'hF; m1_wdata = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0; mem_err = 0;
  endtask

  // Leaves the bench 1 time unit after a clock edge with reset released.
  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    #4;
    if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end n_cmp++;
    if ({m0_gnt, m1_gnt} !== 2'b00) begin n_fail++; $display("FAIL reset_gnt: got %b want 00", {m0_gnt, m1_gnt}); end n_cmp++;
    if ({m0_rvalid, m1_rvalid} !== 2'b00) begin n_fail++; $display("FAIL reset_rvalid: got %b want 00", {m0_rvalid, m1_rvalid}); end n_cmp++;
    if (outstanding !== 2'd0) begin n_fail++; $display("FAIL reset_outstanding: got %0d want 0", outstanding); end n_cmp++;
    if (perr !== 1'b0) begin n_fail++; $display("FAIL reset_perr: got %b want 0", perr); end n_cmp++;
  endtask

  task automatic test_single_read();
    do_reset();
    m0_req = 1; m0_addr = 32'h100; mem_gnt = 1;
    #4;
    if (m0_gnt !== 1'b1) begin n_fail++; $display("FAIL single_m0_gnt: got %b want 1", m0_gnt); end n_cmp++;
    if (m1_gnt !== 1'b0) begin n_fail++; $display("FAIL single_m1_gnt: got %b want 0", m1_gnt); end n_cmp++;
    if (mem_addr !== 32'h100) begin n_fail++; $display("FAIL single_addr: got %h want 00000100", mem_addr); end n_cmp++;
    next_cycle();
    m0_req = 0; m0_addr = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
    #4;
    if (outstanding !== 2'd1) begin n_fail++; $display("FAIL single_outstanding: got %0d want 1", outstanding); end n_cmp++;
    if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_rsp: got %b/%h want 1/deadbeef", m0_rvalid, m0_rdata); end n_cmp++;
    if (m1_rvalid !== 1'b0 || m1_rdata !== 32'h0) begin n_fail++; $display("FAIL single_m1_rsp: got %b/%h want 0/00000000", m1_rvalid, m1_rdata); end n_cmp++;
    next_cycle();
    mem_rvalid = 0; mem_rdata = 0;
    #4;
    if (outstanding !== 2'd0) begin n_fail++; $display("FAIL single_drain: got %0d want 0", outstanding); end n_cmp++;
  endtask

  task automatic test_arbitration();
    logic [0:0] grantee [5];
    logic [0:0] exp_g;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      if (k > 0) next_cycle();
`ifdef OBI_ARB_ROUND_ROBIN_EN
      exp_g = 1'(k % 2);
`else
      exp_g = 1'b0;
`endif
      grantee[k] = exp_g;
      m0_req = (k < 4); m0_addr = 32'h200;
      m1_req = (k < 4); m1_addr = 32'h300;
      mem_gnt = (k < 4); mem_rvalid = (k > 0); mem_rdata = 32'h1000 + k;
      #4;
      if (k < 4) begin
        if ({m1_gnt, m0_gnt} !== (exp_g ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL arb_gnt[%0d]: got m1/m0=%b%b want grantee %0d", k, m1_gnt, m0_gnt, exp_g); end n_cmp++;
        if (mem_addr !== (exp_g ? 32'h300 : 32'h200)) begin n_fail++; $display("FAIL arb_addr[%0d]: got %h want grantee %0d", k, mem_addr, exp_g); end n_cmp++;
      end
      if (k > 0) begin
        if ({m1_rvalid, m0_rvalid} !== (grantee[k-1] ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL arb_rvalid[%0d]: got m1/m0=%b%b want requester %0d", k, m1_rvalid, m0_rvalid, grantee[k-1]); end n_cmp++;
        if ((grantee[k-1] ? m1_rdata : m0_rdata) !== (32'h1000 + k)) begin n_fail++; $display("FAIL arb_rdata[%0d]: got %h/%h want %h", k, m0_rdata, m1_rdata, 32'h1000 + k); end n_cmp++;
      end
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_hold();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      if (k > 0) next_cycle();
      m0_req = 1; m0_addr = 32'hA0;
      m1_req = (k > 0); m1_addr = 32'hB0;
      mem_gnt = 0;
      #4;
      if (mem_req !== 1'b1 || mem_addr !== 32'hA0) begin n_fail++; $display("FAIL hold_addr[%0d]: got %b/%h want 1/000000a0", k, mem_req, mem_addr); end n_cmp++;
      if ({m1_gnt, m0_gnt} !== 2'b00) begin n_fail++; $display("FAIL hold_gnt[%0d]: got %b%b want 00", k, m1_gnt, m0_gnt); end n_cmp++;
    end
    next_cycle();
    mem_gnt = 1;
    #4;
    if ({m1_gnt, m0_gnt} !== 2'b01 || mem_addr !== 32'hA0) begin n_fail++; $display("FAIL hold_release: got gnt %b%b addr %h want 01/000000a0", m1_gnt, m0_gnt, mem_addr); end n_cmp++;
    next_cycle();
    m0_req = 0;
    #4;
    if ({m1_gnt, m0_gnt} !== 2'b10 || mem_addr !== 32'hB0) begin n_fail++; $display("FAIL hold_m1_next: got gnt %b%b addr %h want 10/000000b0", m1_gnt, m0_gnt, mem_addr); end n_cmp++;
    next_cycle();
    m1_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h11;
    #4;
    if (m0_rvalid !== 1'b1 || m0_rdata !== 32'h11 || m1_rvalid !== 1'b0) begin n_fail++; $display("FAIL hold_rsp0: got %b/%h/%b want 1/00000011/0", m0_rvalid, m0_rdata, m1_rvalid); end n_cmp++;
    next_cycle();
    mem_rdata = 32'h22;
    #4;
    if (m1_rvalid !== 1'b1 || m1_rdata !== 32'h22 || m0_rvalid !== 1'b0) begin n_fail++; $display("FAIL hold_rsp1: got %b/%h/%b want 1/00000022/0", m1_rvalid, m1_rdata, m0_rvalid); end n_cmp++;
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_full();
    do_reset();
    m0_req = 1; m0_addr = 32'hC0; mem_gnt = 1;
    #4;
    if (m0_gnt !== 1'b1) begin n_fail++; $display("FAIL full_g0: got %b want 1", m0_gnt); end n_cmp++;
    next_cycle();
    m0_req = 0; m1_req = 1; m1_addr = 32'hD0;
    #4;
    if (m1_gnt !== 1'b1) begin n_fail++; $display("FAIL full_g1: got %b want 1", m1_gnt); end n_cmp++;
    next_cycle();
    m1_req = 0; m0_req = 1; m0_addr = 32'hE0;
    #4;
    if (outstanding !== 2'd2) begin n_fail++; $display("FAIL full_count: got %0d want 2", outstanding); end n_cmp++;
    if (mem_req !== 1'b0 || m0_gnt !== 1'b0) begin n_fail++; $display("FAIL full_block: got req %b gnt %b want 0/0", mem_req, m0_gnt); end n_cmp++;
    next_cycle();
    mem_rvalid = 1; mem_rdata = 32'h55;
    #4;
    if (m0_rvalid !== 1'b1 || m0_rdata !== 32'h55 || m1_rvalid !== 1'b0) begin n_fail++; $display("FAIL full_rsp: got %b/%h/%b want 1/00000055/0", m0_rvalid, m0_rdata, m1_rvalid); end n_cmp++;
    if (mem_req !== 1'b0 || m0_gnt !== 1'b0) begin n_fail++; $display("FAIL full_pop_nogrant: got req %b gnt %b want 0/0", mem_req, m0_gnt); end n_cmp++;
    next_cycle();
    m0_req = 0; mem_gnt = 0; mem_rvalid = 0;
    #4;
    if (outstanding !== 2'd1) begin n_fail++; $display("FAIL full_after_pop: got %0d want 1", outstanding); end n_cmp++;
    next_cycle();
    mem_rvalid = 1; mem_rdata = 32'h66;
    #4;
    if (m1_rvalid !== 1'b1 || m1_rdata !== 32'h66) begin n_fail++; $display("FAIL full_rsp1: got %b/%h want 1/00000066", m1_rvalid, m1_rdata); end n_cmp++;
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_protocol_err();
    do_reset();
    mem_rvalid = 1; mem_rdata = 32'h77;
    #4;
    if ({m1_rvalid, m0_rvalid} !== 2'b00) begin n_fail++; $display("FAIL perr_dropped: got %b%b want 00", m1_rvalid, m0_rvalid); end n_cmp++;
    next_cycle();
    mem_rvalid = 0;
    #4;
    if (perr !== 1'b1) begin n_fail++; $display("FAIL perr_set: got %b want 1", perr); end n_cmp++;
    next_cycle();
    #4;
    if (perr !== 1'b1) begin n_fail++; $display("FAIL perr_sticky: got %b want 1", perr); end n_cmp++;
    do_reset();
    #4;
    if (perr !== 1'b0) begin n_fail++; $display("FAIL perr_cleared: got %b want 0", perr); end n_cmp++;
  endtask

  task automatic test_reset_in_hold();
    do_reset();
    m0_req = 1; m0_addr = 32'h40; mem_gnt = 1;
    #4;
    next_cycle();
    m0_addr = 32'h44; mem_gnt = 0;
    #4;
    if (outstanding !== 2'd1 || mem_req !== 1'b1) begin n_fail++; $display("FAIL rsthold_setup: got cnt %0d req %b want 1/1", outstanding, mem_req); end n_cmp++;
    next_cycle();
    rst = 1; idle_inputs();
    next_cycle();
    rst = 0;
    #4;
    if (outstanding !== 2'd0) begin n_fail++; $display("FAIL rsthold_count: got %0d want 0", outstanding); end n_cmp++;
    if ({mem_req, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, perr} !== 6'b0) begin n_fail++; $display("FAIL rsthold_outputs: got %b want 000000", {mem_req, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, perr}); end n_cmp++;
    next_cycle();
    mem_rvalid = 1;
    #4;
    if ({m1_rvalid, m0_rvalid} !== 2'b00) begin n_fail++; $display("FAIL rsthold_stale_rsp: got %b%b want 00", m1_rvalid, m0_rvalid); end n_cmp++;
    next_cycle();
    mem_rvalid = 0;
    #4;
    if (perr !== 1'b1) begin n_fail++; $display("FAIL rsthold_perr: got %b want 1", perr); end n_cmp++;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_single_read();
    test_arbitration();
    test_hold();
    test_full();
    test_protocol_err();
    test_reset_in_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
